mem_port_arbiter: RTL

Two-requester arbiter that shares the single read/write port (port 1) of the dual-port word RAM between the CPU load/store unit (m0) and a secondary bus master such as the firmware loader or debug DMA (m1). Port 2 stays dedicated to instruction fetch and is untouched. The block grants at most one access per cycle with round-robin fairness, supports an m1 burst lock, and returns registered read data with a one-cycle completion strobe per requester.

---
 rtl/mem_port_arbiter_if.sv | 62 ++++++
 rtl/mem_port_arbiter.sv | 100 ++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//   Bundles the two requester ports, the RAM port-1 signals and the
//   arbiter's debug state into one interface.
//   Modports:
//     slave  - the arbiter: takes requests and mem_rdata, drives grants,
//              completions, the RAM port and the debug state.
//     master - the surrounding system (requesters + RAM): the mirror view.
//   Signals:
//     m0_*/m1_*   request, address, write data, byte strobes, grant,
//                 completion pulse and registered read data per requester
//     m1_lock     m1 burst lock
//     mem_*       RAM port 1 (addr, wdata, wenable out; rdata in)
//     dbg_last    requester granted most recently (0 = m0, 1 = m1)
//     dbg_lock    current burst-lock state
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 14
);
  logic                  m0_req;
  logic [ADDR_WIDTH-1:0] m0_addr;
  logic [31:0]           m0_wdata;
  logic [3:0]            m0_wstrb;
  logic                  m0_gnt;
  logic                  m0_rvalid;
  logic [31:0]           m0_rdata;

  logic                  m1_req;
  logic [ADDR_WIDTH-1:0] m1_addr;
  logic [31:0]           m1_wdata;
  logic [3:0]            m1_wstrb;
  logic                  m1_gnt;
  logic                  m1_rvalid;
  logic [31:0]           m1_rdata;
  logic                  m1_lock;

  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;
  logic [3:0]            mem_wenable;
  logic [31:0]           mem_rdata;

  logic                  dbg_last;
  logic                  dbg_lock;

  modport slave (
    input  m0_req, m0_addr, m0_wdata, m0_wstrb,
    output m0_gnt, m0_rvalid, m0_rdata,
    input  m1_req, m1_addr, m1_wdata, m1_wstrb, m1_lock,
    output m1_gnt, m1_rvalid, m1_rdata,
    output mem_addr, mem_wdata, mem_wenable,
    input  mem_rdata,
    output dbg_last, dbg_lock
  );

  modport master (
    output m0_req, m0_addr, m0_wdata, m0_wstrb,
    input  m0_gnt, m0_rvalid, m0_rdata,
    output m1_req, m1_addr, m1_wdata, m1_wstrb, m1_lock,
    input  m1_gnt, m1_rvalid, m1_rdata,
    input  mem_addr, mem_wdata, mem_wenable,
    output mem_rdata,
    input  dbg_last, dbg_lock
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares RAM port 1 between the CPU load/store unit (m0) and a secondary
//   bus master (m1). One access per cycle, round-robin on contention,
//   optional m1 burst lock, registered read data with a one-cycle
//   completion pulse per requester.
//   Ports:
//     clk  - system clock, all state on posedge
//     rst  - asynchronous active-high reset
//     bus  - mem_port_arbiter_if.slave (requesters, RAM port, debug state)
//
// Handshake: a requester raises mX_req with its fields stable and keeps them
// stable until the cycle mX_gnt is high; that cycle is the access. mX_gnt is
// combinational (same-cycle grant). The RAM performs the access on the
// closing edge, and mX_rvalid pulses for one cycle after it with mX_rdata
// holding what the RAM returned during the grant cycle (pre-write contents
// for writes). There is no backpressure on the completion side.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 14
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);

  // Encoding of the "last granted" register.
  localparam logic [0:0] SEL_M0 = 1'b0;
  localparam logic [0:0] SEL_M1 = 1'b1;

  logic [0:0]  last_q;
  logic        lock_q;
  logic        lock_eff;
  logic        m0_gnt;
  logic        m1_gnt;
  logic        m0_rvalid_q;
  logic        m1_rvalid_q;
  logic [31:0] m0_rdata_q;
  logic [31:0] m1_rdata_q;

  // Arbitration. m1 wins when locked, when m0 is idle, or when m0 was served
  // last; m0 takes anything m1 does not. Grants are forced low during reset
  // so the RAM cannot be written while rst is high.
  always_comb begin
    lock_eff = lock_q & bus.m1_req;
    m1_gnt   = ~rst & bus.m1_req & (lock_eff | ~bus.m0_req | (last_q == SEL_M0));
    m0_gnt   = ~rst & bus.m0_req & ~m1_gnt;
  end

  // Port mux. With no grant the address/data follow m0 (harmless, keeps the
  // mux small) and the write enable is held off.
  always_comb begin
    bus.mem_addr    = bus.m0_addr;
    bus.mem_wdata   = bus.m0_wdata;
    bus.mem_wenable = 4'h0;
    if (m1_gnt) begin
      bus.mem_addr    = bus.m1_addr;
      bus.mem_wdata   = bus.m1_wdata;
      bus.mem_wenable = bus.m1_wstrb;
    end else if (m0_gnt) begin
      bus.mem_wenable = bus.m0_wstrb;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q      <= SEL_M1;
      lock_q      <= 1'b0;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      m0_rdata_q  <= 32'h0;
      m1_rdata_q  <= 32'h0;
    end else begin
      m0_rvalid_q <= m0_gnt;
      m1_rvalid_q <= m1_gnt;
      if (m0_gnt) begin
        m0_rdata_q <= bus.mem_rdata;
        last_q     <= SEL_M0;
      end
      if (m1_gnt) begin
        m1_rdata_q <= bus.mem_rdata;
        last_q     <= SEL_M1;
      end
      // An idle m1 always releases the lock so it can never starve m0.
      if (!bus.m1_req) begin
        lock_q <= 1'b0;
      end else if (m1_gnt) begin
        lock_q <= bus.m1_lock;
      end
    end
  end

  assign bus.m0_gnt    = m0_gnt;
  assign bus.m1_gnt    = m1_gnt;
  assign bus.m0_rvalid = m0_rvalid_q;
  assign bus.m1_rvalid = m1_rvalid_q;
  assign bus.m0_rdata  = m0_rdata_q;
  assign bus.m1_rdata  = m1_rdata_q;
  assign bus.dbg_last  = last_q[0];
  assign bus.dbg_lock  = lock_q;

endmodule
